tl_ad_buffer: RTL
=================

# tl_ad_buffer

TileLink-UL two-channel (A/D) decoupling buffer with an outstanding-request limiter, placed directly upstream of the TileLink FIFO fixer on the peripheral bus. It registers the A channel through a 2-entry queue, optionally registers the D channel the same way, and caps the number of in-flight requests. This breaks long combinational ready/valid paths between the crossbar and the fixer.

## Interface
Parameters:
- MAX_INFLIGHT, 8, maximum outstanding A requests without a D response; legal range 1..15.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- auto_in_a_valid / auto_in_a_ready  in / out  1  upstream A handshake.
- auto_in_a_bits_*  in  121  A payload, fields in order:
  - opcode[3], param[3], size[3], source[8]
  - address[31], mask[8], data[64], corrupt[1]
- auto_out_a_valid / auto_out_a_ready  out / in  1  A handshake toward the fixer.
- auto_out_a_bits_*  out  121  same fields as auto_in_a_bits_*.
- auto_out_d_valid / auto_out_d_ready  in / out  1  D handshake from the fixer.
- auto_out_d_bits_*  in  83  D payload, fields in order:
  - opcode[3], param[2], size[3], source[8]
  - sink[1], denied[1], data[64], corrupt[1]
- auto_in_d_valid / auto_in_d_ready  out / in  1  D handshake toward upstream.
- auto_in_d_bits_*  out  83  same fields as auto_out_d_bits_*.
- io_inflight  out  4  current outstanding count.
- io_error  out  1  sticky flag: D response accepted with no request outstanding.

## Operation
- Fire on any channel = valid && ready in the same cycle.
- **A queue**: 2-entry FIFO, storing full payload.
  - auto_in_a_ready = queue not full.
  - auto_out_a_valid = queue not empty && inflight < MAX_INFLIGHT.
  - Head payload is driven on auto_out_a_bits_* whenever the queue is non-empty.
- **D queue**: 2-entry FIFO from auto_out_d to auto_in_d.
  - auto_out_d_ready = D queue not full.
  - auto_in_d_valid = D queue not empty.
- **Inflight counter** (4 bits):
  - +1 on auto_out_a fire; −1 on auto_in_d fire.
  - Both in the same cycle: count unchanged.
  - Never exceeds MAX_INFLIGHT, because A issue is gated by the count.
- **Underflow**: an auto_in_d fire while count == 0 leaves count at 0 and sets io_error. io_error is cleared only by reset.
- Payloads pass through unmodified; no field is decoded or checked.
- **FIFO corner cases**, applied per queue:
  - Full: enqueue is blocked by ready = 0.
  - Empty with simultaneous enqueue: no bypass; data appears next cycle.
  - Full with simultaneous dequeue: ready stays 0 that cycle; no enqueue.
- Pointer wrap: 1-bit read and write pointers plus a 2-bit count; wrap from entry 1 to entry 0.

## Timing
- While reset is high and on the first cycle after it:
  - Queues are empty and count = 0.
  - All valid outputs are 0, io_inflight = 0, io_error = 0.
  - auto_in_a_ready and auto_out_d_ready are forced 0 while reset is high.
- Reset mid-operation discards all queued beats in the same cycle. The counter zeroes with no handshake.
- A latency: auto_in_a fire at cycle N gives auto_out_a_valid at N+1, provided the limiter permits.
- D latency: the same, 1 cycle.
- Throughput: 1 beat/cycle per channel when the downstream ready is held high.
- No output depends combinationally on the same-side input valid.
- auto_out_a_valid depends only on registered state.
- io_inflight updates on the cycle after the fire that changes it.

## Configuration
- Macro: TL_AD_BUFFER_D_QUEUE_EN.
- Defined: the D channel uses the 2-entry queue described above.
- Undefined: the D channel is a combinational pass-through with zero latency:
  - auto_in_d_valid = auto_out_d_valid.
  - auto_out_d_ready = auto_in_d_ready.
  - Payload wired straight through.
- In both cases the counter decrements on auto_in_d fire and the A path is unchanged.

## Test plan
- **Reset check**: hold reset 3 cycles, then release.
  - During reset: all valids = 0 and readies = 0.
  - After release: io_inflight = 0, io_error = 0, and auto_in_a_ready = 1 on the first post-reset cycle.
- **Streaming**: send 10 Gets, sources 0..9, address 0x1000_0000 + 8i, out_a_ready = 1, out_d returns each one 2 cycles later.
  - Requests appear in order, one cycle after each in-fire.
  - io_inflight peaks at 3 and ends at 0.
- **Limiter**, MAX_INFLIGHT = 8: issue 12 requests with no D responses.
  - Exactly 8 out-fires occur and io_inflight = 8.
  - The A queue fills (2 beats), so auto_in_a_ready = 0 and 10 in-fires occur in total.
  - After one D response: exactly one more out-fire.
- **Backpressure**: toggle out_a_ready 1,0,0,1 and in_d_ready 0,1,0,1 under continuous traffic.
  - No beat is lost or duplicated; payload is bit-exact, including data 0xDEAD_BEEF_0123_4567 and corrupt = 1.
- **Underflow**: inject a D response with count 0.
  - io_error = 1 from the next cycle and remains set after 20 idle cycles.
  - io_inflight stays 0.
  - A subsequent reset clears io_error.
- **Simultaneous events and mid-operation reset**:
  - A out-fire and D in-fire in the same cycle at count 5 leaves count 5.
  - Reset asserted with both queues full: all valids drop, and the queued beats never emerge.

Source files
------------

// File: rtl/tl_ad_buffer.sv
// tl_ad_buffer: TileLink-UL A/D decoupling buffer with an outstanding-request limiter.
// The A channel always passes through a 2-entry queue. The D channel uses a matching
// queue when TL_AD_BUFFER_D_QUEUE_EN is defined; otherwise it is a zero-latency wire path.
// Neither queue bypasses: a beat enqueued into an empty queue appears on the next cycle.

// Two-entry FIFO with 1-bit pointers and a 2-bit occupancy count.
module tl_ad_buffer_q2 #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_enq_valid,
    output logic         o_enq_ready,
    input  logic [W-1:0] i_enq_bits,
    output logic         o_deq_valid,
    input  logic         i_deq_ready,
    output logic [W-1:0] o_deq_bits
);
    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_enq;
    logic         w_deq;

    // Handshakes are masked during reset so queued beats are dropped in the reset cycle.
    assign o_enq_ready = !reset && (r_count != 2'd2);
    assign o_deq_valid = !reset && (r_count != 2'd0);
    assign o_deq_bits  = r_mem[r_rptr];
    assign w_enq       = i_enq_valid && o_enq_ready;
    assign w_deq       = o_deq_valid && i_deq_ready;

    // Storage is write-only on enqueue and needs no reset.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_mem[r_wptr] <= i_enq_bits;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) r_wptr <= ~r_wptr;
            if (w_deq) r_rptr <= ~r_rptr;
            r_count <= r_count + 2'(w_enq) - 2'(w_deq);
        end
    end
endmodule

module tl_ad_buffer #(
    parameter int MAX_INFLIGHT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        auto_in_a_valid,
    output logic        auto_in_a_ready,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [7:0]  auto_in_a_bits_source,
    input  logic [30:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    output logic        auto_out_a_valid,
    input  logic        auto_out_a_ready,
    output logic [2:0]  auto_out_a_bits_opcode,
    output logic [2:0]  auto_out_a_bits_param,
    output logic [2:0]  auto_out_a_bits_size,
    output logic [7:0]  auto_out_a_bits_source,
    output logic [30:0] auto_out_a_bits_address,
    output logic [7:0]  auto_out_a_bits_mask,
    output logic [63:0] auto_out_a_bits_data,
    output logic        auto_out_a_bits_corrupt,
    input  logic        auto_out_d_valid,
    output logic        auto_out_d_ready,
    input  logic [2:0]  auto_out_d_bits_opcode,
    input  logic [1:0]  auto_out_d_bits_param,
    input  logic [2:0]  auto_out_d_bits_size,
    input  logic [7:0]  auto_out_d_bits_source,
    input  logic        auto_out_d_bits_sink,
    input  logic        auto_out_d_bits_denied,
    input  logic [63:0] auto_out_d_bits_data,
    input  logic        auto_out_d_bits_corrupt,
    output logic        auto_in_d_valid,
    input  logic        auto_in_d_ready,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [7:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt,
    output logic [3:0]  io_inflight,
    output logic        io_error
);
    localparam logic [3:0] LP_MAX = 4'(MAX_INFLIGHT);

    logic [120:0] w_a_in_bits;
    logic [120:0] w_a_out_bits;
    logic         w_a_nonempty;
    logic         w_a_permit;
    logic         w_a_fire;
    logic [82:0]  w_d_in_bits;
    logic [82:0]  w_d_out_bits;
    logic         w_d_fire;
    logic [3:0]   r_inflight;
    logic         r_error;

    assign w_a_in_bits = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                          auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                          auto_in_a_bits_data, auto_in_a_bits_corrupt};
    assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
            auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
            auto_out_a_bits_data, auto_out_a_bits_corrupt} = w_a_out_bits;

    // The limiter only looks at the registered count, so out_a_valid never sees in_a_valid.
    assign w_a_permit       = (r_inflight < LP_MAX);
    assign auto_out_a_valid = w_a_nonempty && w_a_permit;
    assign w_a_fire         = auto_out_a_valid && auto_out_a_ready;

    tl_ad_buffer_q2 #(.W(121)) u_a_q (
        .clock       (clock),
        .reset       (reset),
        .i_enq_valid (auto_in_a_valid),
        .o_enq_ready (auto_in_a_ready),
        .i_enq_bits  (w_a_in_bits),
        .o_deq_valid (w_a_nonempty),
        .i_deq_ready (auto_out_a_ready && w_a_permit),
        .o_deq_bits  (w_a_out_bits)
    );

    assign w_d_in_bits = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                          auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                          auto_out_d_bits_data, auto_out_d_bits_corrupt};
    assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
            auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
            auto_in_d_bits_data, auto_in_d_bits_corrupt} = w_d_out_bits;

`ifdef TL_AD_BUFFER_D_QUEUE_EN
    tl_ad_buffer_q2 #(.W(83)) u_d_q (
        .clock       (clock),
        .reset       (reset),
        .i_enq_valid (auto_out_d_valid),
        .o_enq_ready (auto_out_d_ready),
        .i_enq_bits  (w_d_in_bits),
        .o_deq_valid (auto_in_d_valid),
        .i_deq_ready (auto_in_d_ready),
        .o_deq_bits  (w_d_out_bits)
    );
`else
    // Zero-latency D path; reset still masks both handshake directions.
    assign auto_in_d_valid  = !reset && auto_out_d_valid;
    assign auto_out_d_ready = !reset && auto_in_d_ready;
    assign w_d_out_bits     = w_d_in_bits;
`endif

    assign w_d_fire = auto_in_d_valid && auto_in_d_ready;

    // Outstanding-request count and sticky underflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight <= 4'd0;
            r_error    <= 1'b0;
        end else begin
            if (w_d_fire && (r_inflight == 4'd0)) begin
                r_error <= 1'b1;
            end
            if (w_a_fire && !w_d_fire) begin
                r_inflight <= r_inflight + 4'd1;
            end else if (!w_a_fire && w_d_fire && (r_inflight != 4'd0)) begin
                r_inflight <= r_inflight - 4'd1;
            end
        end
    end

    assign io_inflight = r_inflight;
    assign io_error    = r_error;
endmodule
